// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: write-back source encodings, write-control
// field positions and the hardwired zero register index.
package mips_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_LINK = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

  localparam int WE_REG_WRITE = 0;
  localparam int WE_WB_SEL_HI = 2;
  localparam int WE_WB_SEL_LO = 1;
  localparam int REG_ZERO     = 0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back and ID read-port bundle; master drives the pipeline
// side, slave is the register file.
interface wb_regfile_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 32
);
  logic [DW-1:0] alu_result_in;
  logic [DW-1:0] data_from_mem_in;
  logic [DW-1:0] pc_after_add_in;
  logic [AW-1:0] write_address_in;
  logic [2:0]    we_in;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic [DW-1:0] wb_data;
  logic          wb_valid;
  logic [CW-1:0] wb_count;

  modport master (
    output alu_result_in, data_from_mem_in, pc_after_add_in,
           write_address_in, we_in, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wb_data, wb_valid, wb_count
  );

  modport slave (
    input  alu_result_in, data_from_mem_in, pc_after_add_in,
           write_address_in, we_in, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wb_data, wb_valid, wb_count
  );
endinterface

// File: rtl/wb_regfile_core.sv
// Raw register storage: one write port, two combinational read ports,
// whole array cleared by the asynchronous active-low reset.
module reg_file_core #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] regs [2**AW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: source select, register-zero rules, commit counter.
// Define WB_BYPASS_EN for a write-first register file (same-cycle bypass).
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 32
) (
  input logic          clk,
  input logic          rst,
  wb_regfile_if.slave  bus
);

  wb_sel_e       wb_sel;
  logic [DW-1:0] wb_data;
  logic          wb_valid;
  logic [DW-1:0] raw_a;
  logic [DW-1:0] raw_b;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic [CW-1:0] count_q;

  assign wb_sel = wb_sel_e'(bus.we_in[WE_WB_SEL_HI:WE_WB_SEL_LO]);

  // The reserved encoding falls back to the ALU result.
  always_comb begin
    wb_data = bus.alu_result_in;
    case (wb_sel)
      WB_SEL_MEM:  wb_data = bus.data_from_mem_in;
      WB_SEL_LINK: wb_data = bus.pc_after_add_in;
      default:     wb_data = bus.alu_result_in;
    endcase
  end

  assign wb_valid = bus.we_in[WE_REG_WRITE] &&
                    (bus.write_address_in != AW'(REG_ZERO));

  reg_file_core #(.DW(DW), .AW(AW)) u_core (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_valid),
    .waddr   (bus.write_address_in),
    .wdata   (wb_data),
    .raddr_a (bus.rd_addr_a),
    .raddr_b (bus.rd_addr_b),
    .rdata_a (raw_a),
    .rdata_b (raw_b)
  );

  // Zero-register masking is applied last so it also overrides the bypass.
  always_comb begin
    rd_a = raw_a;
    rd_b = raw_b;
`ifdef WB_BYPASS_EN
    if (wb_valid && (bus.rd_addr_a == bus.write_address_in)) rd_a = wb_data;
    if (wb_valid && (bus.rd_addr_b == bus.write_address_in)) rd_b = wb_data;
`endif
    if (bus.rd_addr_a == AW'(REG_ZERO)) rd_a = '0;
    if (bus.rd_addr_b == AW'(REG_ZERO)) rd_b = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (wb_valid) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign bus.wb_data   = wb_data;
  assign bus.wb_valid  = wb_valid;
  assign bus.rd_data_a = rd_a;
  assign bus.rd_data_b = rd_b;
  assign bus.wb_count  = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile (CW=4 to reach counter wrap); the
// reference model follows WB_BYPASS_EN the same way the design does.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  typedef struct {
    logic [DW-1:0] rda;
    logic [DW-1:0] rdb;
    logic [DW-1:0] wbd;
    logic          wbv;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t        exp_q[$];
  logic [31:0] model_regs [32];
  int          model_count = 0;

  wb_regfile_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

  wb_regfile #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h @%0t",
               name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] modelWbData(input logic [2:0] we,
      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
    if (we[2:1] == 2'd1) return mem;
    if (we[2:1] == 2'd2) return pc;
    return alu;
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] ra,
      input logic commit, input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (commit && ra == wa) return wd;
`endif
    return model_regs[ra];
  endfunction

  // Drive one MEM/WB instruction, queue what the DUT must show this cycle,
  // then advance the model across the clock edge.
  task automatic applyStimulus(input logic [2:0] we, input logic [4:0] wa,
      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
      input logic [4:0] ra, input logic [4:0] rb);
    exp_t        e;
    logic        commit;
    logic [31:0] wd;
    bus.we_in            = we;
    bus.write_address_in = wa;
    bus.alu_result_in    = alu;
    bus.data_from_mem_in = mem;
    bus.pc_after_add_in  = pc;
    bus.rd_addr_a        = ra;
    bus.rd_addr_b        = rb;
    wd     = modelWbData(we, alu, mem, pc);
    commit = we[0] && (wa != 5'd0);
    e.rda  = modelRead(ra, commit, wa, wd);
    e.rdb  = modelRead(rb, commit, wa, wd);
    e.wbd  = wd;
    e.wbv  = commit;
    e.cnt  = CW'(model_count);
    exp_q.push_back(e);
    if (commit) begin
      model_regs[wa] = wd;
      model_count    = (model_count + 1) % (2**CW);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic modelClear();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_count = 0;
  endtask

  // Pulse reset between edges while a commit to reg 12 is pending.
  task automatic resetMid(input logic [31:0] alu);
    exp_t e;
    bus.we_in            = 3'b001;
    bus.write_address_in = 5'd12;
    bus.alu_result_in    = alu;
    bus.rd_addr_a        = 5'd12;
    bus.rd_addr_b        = 5'd8;
    #1;
    rst = 1'b0;
    modelClear();
    e.rda = 32'd0;
    e.rdb = 32'd0;
`ifdef WB_BYPASS_EN
    e.rda = alu;
`endif
    e.wbd = alu;
    e.wbv = 1'b1;
    e.cnt = '0;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.we_in = 3'b000;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("rd_data_a", bus.rd_data_a, e.rda);
      checkOutput("rd_data_b", bus.rd_data_b, e.rdb);
      checkOutput("wb_data",   bus.wb_data,   e.wbd);
      checkOutput("wb_valid",  32'(bus.wb_valid), 32'(e.wbv));
      checkOutput("wb_count",  32'(bus.wb_count), 32'(e.cnt));
    end
  end

  initial begin
    exp_t e;
    bus.we_in            = 3'b000;
    bus.write_address_in = 5'd0;
    bus.alu_result_in    = 32'd0;
    bus.data_from_mem_in = 32'd0;
    bus.pc_after_add_in  = 32'd0;
    bus.rd_addr_a        = 5'd3;
    bus.rd_addr_b        = 5'd31;
    modelClear();
    #1;
    e.rda = 32'd0; e.rdb = 32'd0; e.wbd = 32'd0; e.wbv = 1'b0; e.cnt = '0;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(3'b001, 5'd8,  32'h11, 32'h0, 32'h0, 5'd8, 5'd9);
    applyStimulus(3'b011, 5'd9,  32'h0, 32'h22, 32'h0, 5'd8, 5'd9);
    applyStimulus(3'b101, 5'd31, 32'h0, 32'h0, 32'h0040_0008, 5'd31, 5'd9);
    applyStimulus(3'b000, 5'd0,  32'h0, 32'h0, 32'h0, 5'd8, 5'd31);

    applyStimulus(3'b001, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 5'd0);
    applyStimulus(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd8);

    applyStimulus(3'b010, 5'd5, 32'h0, 32'h55, 32'h0, 5'd5, 5'd5);
    applyStimulus(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd9);

    applyStimulus(3'b001, 5'd7, 32'h1, 32'h0, 32'h0, 5'd7, 5'd0);
    applyStimulus(3'b001, 5'd7, 32'h2, 32'h0, 32'h0, 5'd7, 5'd7);
    applyStimulus(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7);

    applyStimulus(3'b111, 5'd4, 32'hA4, 32'hB4, 32'hC4, 5'd4, 5'd0);

    resetMid(32'hCAFE_0012);
    applyStimulus(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd12, 5'd8);

    for (int i = 0; i < 17; i++)
      applyStimulus(3'b001, 5'(1 + (i % 31)), 32'(i * 3 + 1), 32'h0, 32'h0,
                    5'd1, 5'(i % 32));
    applyStimulus(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd17, 5'd2);

    for (int i = 0; i < 300; i++) begin
      logic [4:0] wa;
      logic [4:0] ra;
      logic [4:0] rb;
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      applyStimulus(3'($urandom_range(0, 7)), wa, $urandom, $urandom,
                    $urandom, ra, rb);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the pipelined MIPS core. Consumes the MEM/WB pipeline register outputs, selects the write-back value (ALU result, memory load data, or link PC), and commits it to a 32×32 register file. Serves the two combinational read ports used by the ID stage, with optional same-cycle write-through bypass. Keeps a committed-write counter for performance debug.

## Interface
Parameters:
- DW, 32, data width of registers and write-back sources
- AW, 5, register address width (2^AW registers)
- CW, 32, width of committed-write counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; one clock, reset polarity and synchronicity fixed
- alu_result_in  in  DW  ALU result from MEM/WB
- data_from_mem_in  in  DW  load data from MEM/WB
- pc_after_add_in  in  DW  PC+4 (link value) from MEM/WB
- write_address_in  in  AW  destination register from MEM/WB
- we_in  in  3  write control from MEM/WB: bit0 = reg_write, bits[2:1] = wb_sel
- rd_addr_a  in  AW  read port A address (rs)
- rd_addr_b  in  AW  read port B address (rt)
- rd_data_a  out  DW  read port A data
- rd_data_b  out  DW  read port B data
- wb_data  out  DW  selected write-back value (to forwarding unit)
- wb_valid  out  1  commit this cycle: reg_write=1 and write_address_in≠0
- wb_count  out  CW  number of committed writes since reset

## Operation
- wb_sel decode: 00 ALU result; 01 memory data; 10 link PC; 11 reserved, selects ALU result.
- wb_data is combinational from the sources regardless of reg_write.
- Commit: on rising clk with wb_valid=1, regs[write_address_in] <= wb_data.
- Register 0 hardwired to zero: writes to address 0 are dropped, not counted, wb_valid=0; reads of address 0 return 0 always (including bypass path).
- Reads are combinational from the array (plus bypass, see Configuration).
- wb_count increments by 1 on each commit; wraps from 2^CW−1 to 0 silently.
- Both read ports may address the same register, including the one being written; each resolves independently.

## Timing
- Reset (rst=0, asynchronous): all 32 registers clear to 0, wb_count clears to 0 immediately; rd_data_a/b therefore read 0; wb_data/wb_valid remain combinational functions of inputs.
- Reset asserted mid-cycle while a commit is pending: commit is lost; array stays 0 until first clk edge after rst deasserts.
- Write latency: 1 cycle; value visible in array from the edge after commit.
- Read latency: 0 cycles (combinational).
- No handshake: MEM/WB always presents one instruction per cycle; bubbles arrive as reg_write=0.

## Configuration
- WB_BYPASS_EN defined: if wb_valid=1 and rd_addr_x == write_address_in (nonzero), rd_data_x = wb_data in the same cycle (write-first register file; removes the WB→ID hazard).
- WB_BYPASS_EN undefined: rd_data_x always returns array contents (read-first); the hazard unit must stall or forward a cycle to cover WB→ID.

## Structure
- Shared package mips_pkg: WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_LINK=2'b10, WE_REG_WRITE bit index 0, WE_WB_SEL bit range [2:1], REG_ZERO=0.
- One sub-module: reg_file_core (storage array, async-low reset, one write port, two raw read ports); wb_regfile adds source mux, zero-register rules, bypass and counter.

## Test plan
- Reset: write several registers, pulse rst=0 between edges -> all reads 0 at once, wb_count=0.
- Select: we_in=3'b001 alu=0x11, then 3'b011 mem=0x22, then 3'b101 pc=0x0040_0008 to regs 8,9,31 -> reads return 0x11, 0x22, 0x0040_0008; wb_count=3.
- Zero register: we_in=3'b001, write_address_in=0, alu=0xDEAD_BEEF -> wb_valid=0, rd of 0 stays 0, wb_count unchanged.
- No write: we_in=3'b010 to reg 5 with mem=0x55 -> reg 5 unchanged, wb_data=0x55, wb_valid=0.
- Same-cycle read of written reg 7 (old 0x1, new 0x2), both ports -> with WB_BYPASS_EN both return 0x2; without it 0x1 that cycle, 0x2 next cycle.
- Counter wrap with CW=4: 17 commits -> wb_count=1.
